// File: rtl/adder_pkg.sv
// Shared constants and types for the pipelined datapath adder.
package adder_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned CLA_GROUP  = 4;

    typedef logic [ADDR_WIDTH-1:0] word_t;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group: sums its slice given a carry-in and exports
// group generate/propagate for the second-level lookahead.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       group_g,
    output logic       group_p
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Bit-level generate/propagate, flattened internal carries and group G/P.
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

        sum = p ^ c;

        group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        group_p = &p;
    end

endmodule

// File: rtl/adder_32_bits.sv
// Registered carry-lookahead adder: WIDTH/GROUP cla_4bit groups, a group-level
// lookahead carry unit, and one output register stage with carry/overflow/zero.
module adder_32_bits
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_WIDTH,
    // Must stay 4: each group is a cla_4bit instance. WIDTH must be a multiple.
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] total_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NGroups = WIDTH / GROUP;

    logic [NGroups-1:0] grp_g;
    logic [NGroups-1:0] grp_p;
    logic [NGroups:0]   grp_c;
    logic [WIDTH-1:0]   sum;

    logic [WIDTH-1:0] total_d, total_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    for (genvar i = 0; i < NGroups; i++) begin : g_group
        cla_4bit u_cla (
            .a       (A_in[i*GROUP +: GROUP]),
            .b       (B_in[i*GROUP +: GROUP]),
            .cin     (grp_c[i]),
            .sum     (sum[i*GROUP +: GROUP]),
            .group_g (grp_g[i]),
            .group_p (grp_p[i])
        );
    end

    // Second-level lookahead: each group carry-in is the OR over lower groups
    // of that group's G ANDed with every P above it, so no group-to-group ripple.
    always_comb begin
        logic term;
        logic carry;
        grp_c = '0;
        for (int j = 1; j <= int'(NGroups); j++) begin
            carry = 1'b0;
            for (int i = 0; i < j; i++) begin
                term = grp_g[i];
                for (int k = i + 1; k < j; k++) begin
                    term = term & grp_p[k];
                end
                carry = carry | term;
            end
            grp_c[j] = carry;
        end
    end

    // Status flags derived from the unregistered sum.
    always_comb begin
        total_d = sum;
        carry_d = grp_c[NGroups];
        ovf_d   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (sum[WIDTH-1] != A_in[WIDTH-1]);
        zero_d  = (sum == '0);
    end

    // Output register; reset discards this cycle's sum and forces a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            total_q <= total_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign total_out = total_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_32_bits.sv
// Self-checking bench for adder_32_bits: reset, directed corners, mid-stream
// reset, and back-to-back random operands against an arithmetic model.
module tb_adder_32_bits;
    import adder_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    word_t a_in, b_in;
    word_t total_out;
    logic  carry_out, overflow, zero;

    int passed = 0;
    int total  = 0;

    adder_32_bits dut (
        .clk       (clk),
        .rst       (rst),
        .A_in      (a_in),
        .B_in      (b_in),
        .total_out (total_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: unsigned 64-bit sum for carry/result, signed range test for overflow.
    function automatic logic [34:0] ref_add(input word_t a, input word_t b);
        longint unsigned ua, ub, us;
        longint          sa, sb, ss;
        logic [31:0]     s;
        logic            c, v, z;
        ua = 64'(a);
        ub = 64'(b);
        us = ua + ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ss = sa + sb;
        s  = us[31:0];
        c  = (us >= 64'd4294967296);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        z  = (us % 64'd4294967296) == 0;
        return {c, v, z, s};
    endfunction

    // Apply inputs away from the active edge, then sample just after it.
    task automatic step(input logic r, input word_t a, input word_t b);
        @(negedge clk);
        rst  = r;
        a_in = a;
        b_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [34:0] obs;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h1234_5678, 32'h1);
            obs = {carry_out, overflow, zero, total_out};
            total++;
            if (obs !== {3'b001, 32'h0}) begin
                $display("FAIL reset_%0d: got c/v/z=%b total=%h, need c/v/z=001 total=00000000",
                         i, obs[34:32], obs[31:0]);
            end else passed++;
        end
        step(1'b0, 32'h1234_5678, 32'h1);
        obs = {carry_out, overflow, zero, total_out};
        total++;
        if (obs !== {3'b000, 32'h1234_5679}) begin
            $display("FAIL reset_release: got c/v/z=%b total=%h, need c/v/z=000 total=12345679",
                     obs[34:32], obs[31:0]);
        end else passed++;
    endtask

    // Directed corners with hand-derived expectations: {a, b, {c,v,z}, sum}.
    word_t       ca[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hFFFF_FFFF,
                           32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 32'h1234_5678};
    word_t       cb[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_0001,
                           32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 32'h9ABC_DEF0};
    logic [2:0]  cf[8] = '{3'b001, 3'b100, 3'b000, 3'b101, 3'b010, 3'b111, 3'b000, 3'b000};
    word_t       cs[8] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000,
                           32'h8000_0000, 32'h0000_0000, 32'h0001_0000, 32'hACF1_3568};

    task automatic test_corners();
        logic [34:0] obs;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, ca[i], cb[i]);
            obs = {carry_out, overflow, zero, total_out};
            total++;
            if (obs !== {cf[i], cs[i]}) begin
                $display("FAIL corner_%0d %h+%h: got c/v/z=%b total=%h, need c/v/z=%b total=%h",
                         i, ca[i], cb[i], obs[34:32], obs[31:0], cf[i], cs[i]);
            end else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        logic [34:0] obs;
        logic [34:0] exp;
        step(1'b0, 32'h0000_0005, 32'h0000_0007);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        obs = {carry_out, overflow, zero, total_out};
        total++;
        if (obs !== {3'b001, 32'h0}) begin
            $display("FAIL midreset_discard: got c/v/z=%b total=%h, need c/v/z=001 total=00000000",
                     obs[34:32], obs[31:0]);
        end else passed++;
        step(1'b0, 32'h8000_0001, 32'h8000_0001);
        obs = {carry_out, overflow, zero, total_out};
        exp = ref_add(32'h8000_0001, 32'h8000_0001);
        total++;
        if (obs !== exp) begin
            $display("FAIL midreset_resume: got c/v/z=%b total=%h, need c/v/z=%b total=%h",
                     obs[34:32], obs[31:0], exp[34:32], exp[31:0]);
        end else passed++;
    endtask

    // New operands on every cycle; each edge must deliver the previous pair's result.
    task automatic test_back_to_back();
        logic [34:0] obs;
        logic [34:0] exp;
        word_t       a, b;
        int          errs = 0;
        for (int n = 0; n < 10000; n++) begin
            a = $urandom;
            if (n % 16 == 0)     b = ~a + 32'h1;
            else if (n % 8 == 0) b = ~a;
            else                 b = $urandom;
            step(1'b0, a, b);
            obs = {carry_out, overflow, zero, total_out};
            exp = ref_add(a, b);
            total++;
            if (obs !== exp) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d %h+%h: got c/v/z=%b total=%h, need c/v/z=%b total=%h",
                             n, a, b, obs[34:32], obs[31:0], exp[34:32], exp[31:0]);
            end else passed++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        a_in = '0;
        b_in = '0;
        test_reset();
        test_corners();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit, %0d/%0d done", passed, total);
        $fatal(1, "timeout");
    end

endmodule
